// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering each request after a fixed latency.
// Define DMEM_RESPONDER_JITTER_EN to add 0..3 cycles of LFSR-driven latency jitter.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [4:0] LOAD_BASE = 5'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [4:0]    r_cnt;
  logic [4:0]    w_cnt_next;
  logic [4:0]    w_load;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_hold_data;
  logic          r_hold_err;
  logic [31:0]   r_rdata;
  logic          r_resp;
  logic          r_err;
  logic [31:0]   w_cap_data;
  logic          w_cap_err;
  logic [31:0]   w_resp_data;
  logic          w_resp_err;
  logic [31:0]   w_wbits;
  logic          w_req;
  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_unused_addr;

  function automatic logic [31:0] lanes_to_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

  // Upper address bits are deliberately dropped so accesses wrap around the array.
  assign w_idx         = dmem_addr[AW+1:2];
  assign w_unused_addr = ^dmem_addr[31:AW+2];
  assign w_req         = (|dmem_rmask) | (|dmem_wmask);
  assign w_accept      = (r_state == IDLE) && w_req;
  assign w_cap_err     = (|dmem_addr[1:0]) | ((|dmem_rmask) & (|dmem_wmask));
  assign w_cap_data    = w_cap_err ? 32'h0000_0000 : (r_mem[w_idx] & lanes_to_bits(dmem_rmask));
  assign w_wbits       = lanes_to_bits(dmem_wmask);

`ifdef DMEM_RESPONDER_JITTER_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR (taps 8,6,5,4), stepped once per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign w_load = LOAD_BASE + {3'b000, r_lfsr[1:0]};
`else
  assign w_load = LOAD_BASE;
`endif

  // Array write at acceptance; contents survive reset, error requests never write.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && !w_cap_err) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_wbits) | (dmem_wdata & w_wbits);
    end
  end

  // FSM next-state and latency counter.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_next = w_load;
          if (w_load == 5'd0) begin
            w_next = RESP;
          end else begin
            w_next = BUSY;
          end
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == 5'd0) begin
          w_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 5'd1;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 5'd0;
      end
    endcase
  end

  // A zero-latency path enters RESP straight from IDLE, before the hold register is loaded.
  always_comb begin
    w_resp_data = r_hold_data;
    w_resp_err  = r_hold_err;
    if (r_state == IDLE) begin
      w_resp_data = w_cap_data;
      w_resp_err  = w_cap_err;
    end else begin
      w_resp_data = r_hold_data;
      w_resp_err  = r_hold_err;
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Captured response and registered outputs, zero outside the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_data <= 32'h0000_0000;
      r_hold_err  <= 1'b0;
      r_resp      <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_data <= w_cap_data;
        r_hold_err  <= w_cap_err;
      end else begin
        r_hold_data <= r_hold_data;
        r_hold_err  <= r_hold_err;
      end
      r_resp  <= (w_next == RESP);
      r_rdata <= (w_next == RESP) ? w_resp_data : 32'h0000_0000;
      r_err   <= (w_next == RESP) ? w_resp_err : 1'b0;
    end
  end

  assign dmem_rdata = r_rdata;
  assign dmem_resp  = r_resp;
  assign dmem_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expectations, a negedge monitor checks them.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmem_addr = 32'h0;
  logic [3:0]  dmem_rmask = 4'h0;
  logic [3:0]  dmem_wmask = 4'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   neg_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .dmem_err   (dmem_err)
  );

  always #5 clk = ~clk;

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt = neg_cnt + 1;
    if (rst) begin
      n_checks = n_checks + 1;
      if (dmem_resp !== 1'b0 || dmem_rdata !== 32'h0 || dmem_err !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_state: resp=%b rdata=%h err=%b, required 0/00000000/0", dmem_resp, dmem_rdata, dmem_err);
      end
    end else if (dmem_resp === 1'b1) begin
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL spurious_resp: resp=1 at cycle %0d, required no response", neg_cnt);
      end else begin
        e = sb.pop_front();
        if (neg_cnt != e.cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL resp_latency: got cycle %0d, required %0d", neg_cnt, e.cyc);
        end
        n_checks = n_checks + 1;
        if (dmem_rdata !== e.data) begin
          n_fail = n_fail + 1;
          $display("FAIL rdata: got %h, required %h", dmem_rdata, e.data);
        end
        n_checks = n_checks + 1;
        if (dmem_err !== e.err) begin
          n_fail = n_fail + 1;
          $display("FAIL err: got %b, required %b", dmem_err, e.err);
        end
      end
    end else begin
      n_checks = n_checks + 1;
      if (dmem_rdata !== 32'h0 || dmem_err !== 1'b0 || dmem_resp !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL idle_outputs: resp=%b rdata=%h err=%b, required 0/00000000/0", dmem_resp, dmem_rdata, dmem_err);
      end
      if (sb.size() > 0 && sb[0].cyc < neg_cnt) begin
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL missing_resp: no resp by cycle %0d, required at %0d", neg_cnt, sb[0].cyc);
        e = sb.pop_front();
      end
    end
  end

  task automatic clear_inputs();
    dmem_addr  = 32'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    dmem_wdata = 32'h0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       input bit expect_resp);
    exp_t e;
    @(negedge clk);
    #1;
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    if (expect_resp) begin
      e.data = ed;
      e.err  = ee;
      e.cyc  = neg_cnt + 1 + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    issue(a, rm, wm, wd, ed, ee, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // Full write then lane-1 patch, read back the merged word.
    req(32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    req(32'h10, 4'h0, 4'b0010, 32'h0000_5500, 32'h0, 1'b0);
    req(32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAD55EF, 1'b0);

    // Masked read of upper lanes.
    req(32'h10, 4'h0, 4'hF, 32'h12345678, 32'h0, 1'b0);
    req(32'h10, 4'b1100, 4'h0, 32'h0, 32'h12340000, 1'b0);

    // Error requests: misaligned read, read+write, misaligned write; array untouched.
    req(32'h13, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1);
    req(32'h10, 4'hF, 4'h1, 32'hFFFFFFFF, 32'h0, 1'b1);
    req(32'h11, 4'h0, 4'hF, 32'h0, 32'h0, 1'b1);
    req(32'h10, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0);

    // Address wrap modulo 1 KiB.
    req(32'h400, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0);
    req(32'h0, 4'hF, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    req(32'h0, 4'b0001, 4'h0, 32'h0, 32'h000000A5, 1'b0);
    req(32'h400, 4'b0110, 4'h0, 32'h0, 32'h00A5A500, 1'b0);

    // Inputs changing while BUSY must be ignored.
    issue(32'h10, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b1);
    dmem_addr  = 32'h10;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h0;
    @(posedge clk);
    #1;
    clear_inputs();
    drain();
    req(32'h10, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0);

    // Reset while BUSY: response dropped, committed write kept.
    issue(32'h20, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    req(32'h20, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
